router_sync: RTL and testbench
==============================

# router_sync

Synchroniser between the router control FSM/input register and the three output FIFOs of the 1x3 router. Latches the destination address from the header byte and steers the single write strobe to the addressed FIFO. Reports that FIFO's full status back upstream and raises per-channel valid from each FIFO's empty flag. Per-channel watchdogs soft-reset a FIFO whose packet is not read within a fixed number of cycles.

## Interface
Parameters:
- TIMEOUT, 30: consecutive cycles of valid-without-read that trigger a soft reset (legal range 2..31).
- CNT_W, 5: timeout counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- detect_add  in  1  FSM header-detect strobe; load address.
- data_in  in  2  address field, header byte bits [1:0].
- write_enb_reg  in  1  FSM write permission.
- read_enb_0/1/2  in  1 each  downstream read strobes for FIFO 0/1/2.
- empty_0/1/2  in  1 each  FIFO empty flags.
- full_0/1/2  in  1 each  FIFO full flags.
- write_enb  out  3  one-hot FIFO write enables; bit n drives FIFO n.
- fifo_full  out  1  full flag of the addressed FIFO.
- vld_out_0/1/2  out  1 each  channel has data.
- soft_reset_0/1/2  out  1 each  registered one-cycle FIFO clear pulse.

## Operation
- Address register addr[1:0]:
  - Reset value 2'b11 (no destination).
  - Loads data_in on a rising edge with detect_add=1; holds otherwise.
- write_enb (combinational):
  - 000 when write_enb_reg=0.
  - Otherwise decoded from addr: 00→001, 01→010, 10→100, 11→000.
  - Never more than one bit set.
- fifo_full (combinational): full_0/1/2 selected by addr; 0 when addr=11.
- vld_out_n = ~empty_n (combinational, independent of addr).
- Watchdog, per channel n, counter cnt_n[CNT_W-1:0] plus registered soft_reset_n:
  - Stall condition: vld_out_n=1 and read_enb_n=0.
  - On a stalled edge with cnt_n < TIMEOUT-1: cnt_n increments; soft_reset_n←0.
  - On a stalled edge with cnt_n = TIMEOUT-1: cnt_n←0; soft_reset_n←1.
  - On any non-stalled edge: cnt_n←0; soft_reset_n←0.
  - Any single read cycle restarts the count.
  - If the FIFO is still non-empty and unread after a pulse, the next pulse follows after another TIMEOUT stalled edges.
- Channels are fully independent; all three may pulse in the same cycle.
- Reset state: addr=11, all counters 0, soft_reset_0/1/2=0.
  - Resulting outputs: write_enb=000, fifo_full=0, vld_out_n=~empty_n.
  - Reset mid-packet or mid-count abandons the count immediately, with no pulse.

## Timing
- Address latency: 1 cycle. With detect_add and write_enb_reg both high in the same cycle, write_enb and fifo_full use the old addr; the new addr applies from the next cycle.
- write_enb, fifo_full and vld_out_n are combinational from their inputs; no added latency.
- soft_reset_n asserts in the cycle after the TIMEOUT-th consecutive stalled edge and lasts exactly 1 cycle.
  - For TIMEOUT=30 with vld_out_0 rising before edge 1: soft_reset_0 is high between edges 30 and 31.
- read_enb_n asserted while empty_n=1 has no effect; the counter stays 0.
- Changes to full_x or empty_x mid-packet propagate to fifo_full and vld_out in the same cycle.

## Test plan
- Reset: hold resetn=0 with empty_*=1 and full_*=0 → write_enb=000, fifo_full=0, vld_out_*=0, soft_reset_*=0. Release reset → values unchanged.
- Steering: pulse detect_add with data_in=01, then write_enb_reg=1 for 3 cycles → write_enb=010 from the cycle after the latch. Repeat with 10 → 100. Repeat with 11 → 000.
- Full mux: addr=10; toggle full_2 with full_0=full_1=1 → fifo_full follows full_2 only. addr=11 → fifo_full=0.
- Timeout: empty_1=0, read_enb_1=0 for 35 cycles → exactly one soft_reset_1 pulse, after the 30th edge. Hold the stall for 30 more edges → second pulse. soft_reset_0 and soft_reset_2 stay 0 throughout.
- Read restart: empty_0=0 with read_enb_0=1 pulsed at edge 29 → no pulse. The count restarts and the pulse moves to 30 edges after the read.
- Mid-count reset: stall channel 2 for 20 edges, assert resetn=0 asynchronously between edges → soft_reset_2=0 immediately. After release, the first pulse needs a fresh 30 stalled edges.

Source files
------------

// File: rtl/router_sync.sv
// Glue between the 1x3 router FSM and its three output FIFOs: address latch,
// write-strobe steering, full/valid reporting and per-channel stall watchdogs.

module router_sync_wdog #(
    parameter int TIMEOUT = 30,
    parameter int CNT_W   = 5
) (
    input  logic clock,
    input  logic resetn,
    input  logic vld,
    input  logic rd,
    output logic soft_reset
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt;
    logic             stall;

    assign stall = vld & ~rd;

    // Any read or empty cycle restarts the count; the terminal stalled edge
    // wraps the counter so a still-stuck FIFO pulses again TIMEOUT edges later.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt        <= '0;
            soft_reset <= 1'b0;
        end else if (stall) begin
            if (cnt == LAST) begin
                cnt        <= '0;
                soft_reset <= 1'b1;
            end else begin
                cnt        <= cnt + CNT_W'(1);
                soft_reset <= 1'b0;
            end
        end else begin
            cnt        <= '0;
            soft_reset <= 1'b0;
        end
    end
endmodule

module router_sync #(
    parameter int TIMEOUT = 30,
    parameter int CNT_W   = 5
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       detect_add,
    input  logic [1:0] data_in,
    input  logic       write_enb_reg,
    input  logic       read_enb_0,
    input  logic       read_enb_1,
    input  logic       read_enb_2,
    input  logic       empty_0,
    input  logic       empty_1,
    input  logic       empty_2,
    input  logic       full_0,
    input  logic       full_1,
    input  logic       full_2,
    output logic [2:0] write_enb,
    output logic       fifo_full,
    output logic       vld_out_0,
    output logic       vld_out_1,
    output logic       vld_out_2,
    output logic       soft_reset_0,
    output logic       soft_reset_1,
    output logic       soft_reset_2
);
    localparam int NUM_CH = 3;

    logic [1:0]        addr;
    logic [NUM_CH-1:0] empty_v, full_v, rd_v, vld_v, srst_v;

    assign empty_v = {empty_2, empty_1, empty_0};
    assign full_v  = {full_2, full_1, full_0};
    assign rd_v    = {read_enb_2, read_enb_1, read_enb_0};
    assign vld_v   = ~empty_v;

    // 2'b11 means "no destination" until the first header arrives.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            addr <= 2'b11;
        else if (detect_add)
            addr <= data_in;
    end

    always_comb begin
        write_enb = '0;
        if (write_enb_reg) begin
            case (addr)
                2'b00:   write_enb = 3'b001;
                2'b01:   write_enb = 3'b010;
                2'b10:   write_enb = 3'b100;
                default: write_enb = 3'b000;
            endcase
        end
    end

    always_comb begin
        fifo_full = 1'b0;
        case (addr)
            2'b00:   fifo_full = full_v[0];
            2'b01:   fifo_full = full_v[1];
            2'b10:   fifo_full = full_v[2];
            default: fifo_full = 1'b0;
        endcase
    end

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_wdog
            router_sync_wdog #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_wdog (
                .clock      (clock),
                .resetn     (resetn),
                .vld        (vld_v[g]),
                .rd         (rd_v[g]),
                .soft_reset (srst_v[g])
            );
        end
    endgenerate

    assign vld_out_0    = vld_v[0];
    assign vld_out_1    = vld_v[1];
    assign vld_out_2    = vld_v[2];
    assign soft_reset_0 = srst_v[0];
    assign soft_reset_1 = srst_v[1];
    assign soft_reset_2 = srst_v[2];
endmodule

// File: tb/tb_router_sync.sv
// Directed bench for router_sync: steering, full mux, valid and watchdog timing.

module tb_router_sync;
    logic       clock = 1'b0;
    logic       resetn;
    logic       detect_add, write_enb_reg;
    logic [1:0] data_in;
    logic       read_enb_0, read_enb_1, read_enb_2;
    logic       empty_0, empty_1, empty_2;
    logic       full_0, full_1, full_2;
    logic [2:0] write_enb;
    logic       fifo_full;
    logic       vld_out_0, vld_out_1, vld_out_2;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;

    int n_checks = 0;
    int n_fail   = 0;

    router_sync #(.TIMEOUT(30), .CNT_W(5)) dut (
        .clock(clock), .resetn(resetn), .detect_add(detect_add), .data_in(data_in),
        .write_enb_reg(write_enb_reg),
        .read_enb_0(read_enb_0), .read_enb_1(read_enb_1), .read_enb_2(read_enb_2),
        .empty_0(empty_0), .empty_1(empty_1), .empty_2(empty_2),
        .full_0(full_0), .full_1(full_1), .full_2(full_2),
        .write_enb(write_enb), .fifo_full(fifo_full),
        .vld_out_0(vld_out_0), .vld_out_1(vld_out_1), .vld_out_2(vld_out_2),
        .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1), .soft_reset_2(soft_reset_2)
    );

    always #5 clock = ~clock;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; detect_add = 0; write_enb_reg = 0; data_in = 2'b00;
        {read_enb_2, read_enb_1, read_enb_0} = '0;
        {empty_2, empty_1, empty_0} = 3'b111;
        {full_2, full_1, full_0} = 3'b000;
        #3;
        for (int p = 0; p < 2; p++) begin
            n_checks++;
            if ({write_enb, fifo_full} !== 4'b0000) begin
                n_fail++; $display("FAIL reset_we_full[%0d]: got %b/%b want 000/0", p, write_enb, fifo_full);
            end
            n_checks++;
            if ({vld_out_2, vld_out_1, vld_out_0, soft_reset_2, soft_reset_1, soft_reset_0} !== 6'b0) begin
                n_fail++; $display("FAIL reset_vld_srst[%0d]: got %b%b%b/%b%b%b want 000/000", p,
                    vld_out_2, vld_out_1, vld_out_0, soft_reset_2, soft_reset_1, soft_reset_0);
            end
            if (p == 0) begin
                tick(); tick();
                resetn = 1'b1;
                tick();
                // addr=11: even with write permission nothing is enabled
                write_enb_reg = 1'b1; #1;
                n_checks++;
                if (write_enb !== 3'b000) begin
                    n_fail++; $display("FAIL reset_addr11_we: got %b want 000", write_enb);
                end
                write_enb_reg = 1'b0; #1;
            end
        end
    endtask

    task automatic test_steering();
        logic [1:0] addrs [3] = '{2'b01, 2'b10, 2'b11};
        logic [2:0] exp   [3] = '{3'b010, 3'b100, 3'b000};
        for (int k = 0; k < 3; k++) begin
            detect_add = 1'b1; data_in = addrs[k];
            tick();
            detect_add = 1'b0; write_enb_reg = 1'b1;
            for (int c = 0; c < 3; c++) begin
                #1;
                n_checks++;
                if (write_enb !== exp[k]) begin
                    n_fail++; $display("FAIL steer_%b_c%0d: got %b want %b", addrs[k], c, write_enb, exp[k]);
                end
                tick();
            end
            write_enb_reg = 1'b0; #1;
            n_checks++;
            if (write_enb !== 3'b000) begin
                n_fail++; $display("FAIL steer_off_%b: got %b want 000", addrs[k], write_enb);
            end
        end
        // addr=11 now; load 00 with write asserted in the same cycle: old addr applies
        detect_add = 1'b1; data_in = 2'b00; write_enb_reg = 1'b1; #1;
        n_checks++;
        if (write_enb !== 3'b000) begin
            n_fail++; $display("FAIL steer_same_cycle_old: got %b want 000", write_enb);
        end
        tick();
        detect_add = 1'b0; #1;
        n_checks++;
        if (write_enb !== 3'b001) begin
            n_fail++; $display("FAIL steer_same_cycle_new: got %b want 001", write_enb);
        end
        write_enb_reg = 1'b0;
    endtask

    task automatic test_full_mux();
        detect_add = 1'b1; data_in = 2'b10; tick(); detect_add = 1'b0;
        full_0 = 1'b1; full_1 = 1'b1;
        for (int t = 0; t < 4; t++) begin
            full_2 = t[0]; #1;
            n_checks++;
            if (fifo_full !== t[0]) begin
                n_fail++; $display("FAIL full_mux_addr10_t%0d: got %b want %b", t, fifo_full, t[0]);
            end
        end
        full_2 = 1'b0;
        detect_add = 1'b1; data_in = 2'b01; tick(); detect_add = 1'b0;
        full_1 = 1'b0; #1;
        n_checks++;
        if (fifo_full !== 1'b0) begin
            n_fail++; $display("FAIL full_mux_addr01_lo: got %b want 0", fifo_full);
        end
        full_1 = 1'b1; #1;
        n_checks++;
        if (fifo_full !== 1'b1) begin
            n_fail++; $display("FAIL full_mux_addr01_hi: got %b want 1", fifo_full);
        end
        full_2 = 1'b1;
        detect_add = 1'b1; data_in = 2'b11; tick(); detect_add = 1'b0;
        n_checks++;
        if (fifo_full !== 1'b0) begin
            n_fail++; $display("FAIL full_mux_addr11: got %b want 0", fifo_full);
        end
        {full_2, full_1, full_0} = 3'b000;
    endtask

    task automatic test_valid();
        logic [2:0] pat [4] = '{3'b110, 3'b101, 3'b011, 3'b000};
        for (int k = 0; k < 4; k++) begin
            {empty_2, empty_1, empty_0} = pat[k]; #1;
            n_checks++;
            if ({vld_out_2, vld_out_1, vld_out_0} !== ~pat[k]) begin
                n_fail++; $display("FAIL valid_%b: got %b%b%b want %b", pat[k],
                    vld_out_2, vld_out_1, vld_out_0, ~pat[k]);
            end
        end
        {empty_2, empty_1, empty_0} = 3'b111;
        tick(); tick();
    endtask

    task automatic test_timeout();
        int pulses = 0;
        empty_1 = 1'b0;
        for (int e = 1; e <= 65; e++) begin
            tick();
            if (soft_reset_1) pulses++;
            n_checks++;
            if (soft_reset_1 !== (e == 30 || e == 60)) begin
                n_fail++; $display("FAIL timeout_sr1_e%0d: got %b want %b", e, soft_reset_1, (e == 30 || e == 60));
            end
            n_checks++;
            if ({soft_reset_2, soft_reset_0} !== 2'b00) begin
                n_fail++; $display("FAIL timeout_others_e%0d: got %b%b want 00", e, soft_reset_2, soft_reset_0);
            end
        end
        n_checks++;
        if (pulses != 2) begin
            n_fail++; $display("FAIL timeout_pulse_count: got %0d want 2", pulses);
        end
        empty_1 = 1'b1;
        tick();
    endtask

    task automatic test_read_restart();
        // A read on an empty FIFO must not start or disturb anything
        read_enb_2 = 1'b1;
        tick(); tick();
        read_enb_2 = 1'b0;
        empty_0 = 1'b0;
        for (int e = 1; e <= 62; e++) begin
            read_enb_0 = (e == 29);
            tick();
            n_checks++;
            if (soft_reset_0 !== (e == 59)) begin
                n_fail++; $display("FAIL read_restart_sr0_e%0d: got %b want %b", e, soft_reset_0, (e == 59));
            end
        end
        read_enb_0 = 1'b0; empty_0 = 1'b1;
        tick();
    endtask

    task automatic test_midcount_reset();
        empty_2 = 1'b0;
        for (int e = 1; e <= 20; e++) tick();
        #2 resetn = 1'b0; #1;
        n_checks++;
        if ({soft_reset_2, vld_out_2} !== 2'b01) begin
            n_fail++; $display("FAIL midreset_in_reset: got sr2=%b vld2=%b want 0/1", soft_reset_2, vld_out_2);
        end
        tick();
        #2 resetn = 1'b1;
        for (int e = 1; e <= 31; e++) begin
            tick();
            n_checks++;
            if (soft_reset_2 !== (e == 30)) begin
                n_fail++; $display("FAIL midreset_fresh_e%0d: got %b want %b", e, soft_reset_2, (e == 30));
            end
        end
        // Reset landing while the pulse is high clears it at once
        for (int e = 2; e <= 30; e++) tick();
        n_checks++;
        if (soft_reset_2 !== 1'b1) begin
            n_fail++; $display("FAIL midreset_second_pulse: got %b want 1", soft_reset_2);
        end
        #2 resetn = 1'b0; #1;
        n_checks++;
        if (soft_reset_2 !== 1'b0) begin
            n_fail++; $display("FAIL midreset_pulse_clear: got %b want 0", soft_reset_2);
        end
        #2 resetn = 1'b1;
        empty_2 = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_steering();
        test_full_mux();
        test_valid();
        test_timeout();
        test_read_restart();
        test_midcount_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
